// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: EX/MEM and MEM/WB records, control, FSM states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package mem_stage_pkg;

    localparam int XLEN           = 32;
    localparam int REG_ADDR_WIDTH = 5;

    // Load/store width encodings as carried in funct3 of the memory instruction.
    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_mem_e;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_WAIT_GNT,
        MEM_WAIT_RDATA
    } mem_state_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        funct3_mem_e mem_funct3;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0]           alu_result;
        logic [XLEN-1:0]           rs2_data_str;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        ctrl_t                     ctrl;
        logic                      valid_ex_mem;
    } ex_mem_reg_t;

    typedef struct packed {
        logic [XLEN-1:0]           alu_result;
        logic [XLEN-1:0]           mem_rdata;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        ctrl_t                     ctrl;
        logic                      fault;
        logic                      valid_mem_wb;
    } mem_wb_reg_t;

    // True when an access of the given width does not sit on its natural boundary.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if (f3[1])
            mis = (off != 2'b00);
        else if (f3[0])
            mis = off[0];
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering: store data/byte-enable shift, load extract and extend, misalign flag.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_align
    import mem_stage_pkg::*;
#(
    parameter int ADDR_ALIGN_CHECK = 1
) (
    input  funct3_mem_e     funct3,
    input  logic [1:0]      byte_off,
    input  logic            mem_access,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] load_word,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic            misalign
);

    logic [2:0]      f3;
    logic [XLEN-1:0] shifted;

    assign f3       = funct3;
    assign shifted  = load_word >> {byte_off, 3'b000};
    assign misalign = (ADDR_ALIGN_CHECK != 0) && mem_access && is_misaligned(f3, byte_off);

    // Store side: replicate the datum across all lanes and enable only the addressed ones.
    always_comb begin
        be    = 4'b0000;
        wdata = '0;
        case (f3[1:0])
            2'b00: begin
                be    = 4'b0001 << byte_off;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << byte_off;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    // Load side: the addressed lane is shifted down to bit 0, then sign or zero extended.
    always_comb begin
        load_data = shifted;
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_data = {24'b0, shifted[7:0]};
            F3_HU:   load_data = {16'b0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on a req/gnt/rvalid bus and registers the MEM/WB record.
// Latency: 1 cycle for non-memory/store-with-gnt/misalign; loads take at least 2 (gnt, then rvalid).
// Backpressure: mem_stall holds upstream while waiting for gnt or rvalid; a timeout retires with fault.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES   = 64,
    parameter int ADDR_ALIGN_CHECK = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  ex_mem_reg_t               ex_mem_in,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [XLEN-1:0]           dmem_addr,
    output logic [3:0]                dmem_be,
    output logic [XLEN-1:0]           dmem_wdata,
    input  logic                      dmem_gnt,
    input  logic                      dmem_rvalid,
    input  logic [XLEN-1:0]           dmem_rdata,
    output logic [XLEN-1:0]           mem_alu_result,
    output logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                      mem_reg_write,
    output logic                      mem_stall,
    output mem_wb_reg_t               mem_wb_out,
    output logic                      mem_fault
);

    localparam int                CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_wb_reg_t     mem_wb_q, mem_wb_d;
    logic            mem_fault_q, mem_fault_d;

    logic            is_load, is_store, is_mem, misalign;
    logic            req, retire, retire_fault, take_load;
    logic [XLEN-1:0] load_data;

    assign is_load  = ex_mem_in.ctrl.mem_read;
    assign is_store = ex_mem_in.ctrl.mem_write;
    assign is_mem   = is_load | is_store;

    lsu_align #(
        .ADDR_ALIGN_CHECK(ADDR_ALIGN_CHECK)
    ) u_align (
        .funct3    (ex_mem_in.ctrl.mem_funct3),
        .byte_off  (ex_mem_in.alu_result[1:0]),
        .mem_access(is_mem),
        .store_data(ex_mem_in.rs2_data_str),
        .load_word (dmem_rdata),
        .be        (dmem_be),
        .wdata     (dmem_wdata),
        .load_data (load_data),
        .misalign  (misalign)
    );

    // Bus fields come straight from the held EX/MEM record, so they stay stable while stalled.
    assign dmem_req  = req & reset;
    assign dmem_we   = is_store;
    assign dmem_addr = {ex_mem_in.alu_result[XLEN-1:2], 2'b00};

    assign mem_alu_result = ex_mem_in.alu_result;
    assign mem_rd_addr    = ex_mem_in.rd_addr;
    assign mem_reg_write  = ex_mem_in.ctrl.reg_write & ex_mem_in.valid_ex_mem;

    assign mem_wb_out = mem_wb_q;
    assign mem_fault  = mem_fault_q;

    // Bus FSM: next state, request, stall and retire decisions.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req          = 1'b0;
        mem_stall    = 1'b0;
        retire       = 1'b0;
        retire_fault = 1'b0;
        take_load    = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (ex_mem_in.valid_ex_mem) begin
                    if (!is_mem) begin
                        retire = 1'b1;
                    end else if (misalign) begin
                        retire       = 1'b1;
                        retire_fault = 1'b1;
                    end else begin
                        req   = 1'b1;
                        cnt_d = '0;
                        if (dmem_gnt && is_store) begin
                            retire = 1'b1;
                        end else begin
                            mem_stall = 1'b1;
                            state_d   = dmem_gnt ? MEM_WAIT_RDATA : MEM_WAIT_GNT;
                        end
                    end
                end
            end
            MEM_WAIT_GNT: begin
                req = 1'b1;
                if (dmem_gnt) begin
                    cnt_d = '0;
                    if (is_store) begin
                        retire  = 1'b1;
                        state_d = MEM_IDLE;
                    end else begin
                        mem_stall = 1'b1;
                        state_d   = MEM_WAIT_RDATA;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    retire       = 1'b1;
                    retire_fault = 1'b1;
                    cnt_d        = '0;
                    state_d      = MEM_IDLE;
                end else begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            MEM_WAIT_RDATA: begin
                if (dmem_rvalid) begin
                    retire    = 1'b1;
                    take_load = 1'b1;
                    cnt_d     = '0;
                    state_d   = MEM_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    retire       = 1'b1;
                    retire_fault = 1'b1;
                    cnt_d        = '0;
                    state_d      = MEM_IDLE;
                end else begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = MEM_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Next MEM/WB record: a bubble unless something retires this cycle; faults never write rd.
    always_comb begin
        mem_wb_d    = '0;
        mem_fault_d = retire_fault;
        if (retire) begin
            mem_wb_d.alu_result     = ex_mem_in.alu_result;
            mem_wb_d.rd_addr        = ex_mem_in.rd_addr;
            mem_wb_d.ctrl           = ex_mem_in.ctrl;
            mem_wb_d.ctrl.reg_write = ex_mem_in.ctrl.reg_write & ~retire_fault;
            mem_wb_d.mem_rdata      = take_load ? load_data : '0;
            mem_wb_d.fault          = retire_fault;
            mem_wb_d.valid_mem_wb   = 1'b1;
        end
    end

    // State, timeout counter and output record registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= MEM_IDLE;
            cnt_q       <= '0;
            mem_wb_q    <= '0;
            mem_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_wb_q    <= mem_wb_d;
            mem_fault_q <= mem_fault_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed and random loads/stores against a byte-level reference model.
// Latency: expected cycle counts are derived per operation from gnt/rvalid delays.
// Backpressure: the bench plays the memory, delaying gnt and rvalid.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int TMO = 64;

    logic                      clk = 1'b0;
    logic                      reset;
    ex_mem_reg_t               ex_mem_in;
    logic                      dmem_req, dmem_we;
    logic [XLEN-1:0]           dmem_addr;
    logic [3:0]                dmem_be;
    logic [XLEN-1:0]           dmem_wdata;
    logic                      dmem_gnt, dmem_rvalid;
    logic [XLEN-1:0]           dmem_rdata;
    logic [XLEN-1:0]           mem_alu_result;
    logic [REG_ADDR_WIDTH-1:0] mem_rd_addr;
    logic                      mem_reg_write, mem_stall;
    mem_wb_reg_t               mem_wb_out;
    logic                      mem_fault;

    int tests = 0;
    int fails = 0;

    mem_stage #(.TIMEOUT_CYCLES(TMO), .ADDR_ALIGN_CHECK(1)) dut (
        .clk(clk), .reset(reset), .ex_mem_in(ex_mem_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .mem_alu_result(mem_alu_result), .mem_rd_addr(mem_rd_addr),
        .mem_reg_write(mem_reg_write), .mem_stall(mem_stall), .mem_wb_out(mem_wb_out),
        .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte i is enabled when it falls inside [off, off+size).
    function automatic logic [3:0] ref_be(input int size, input int off);
        logic [3:0] b;
        b = '0;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + size) b[i] = 1'b1;
        return b;
    endfunction

    // Every lane carries the datum byte that would land there if the datum were repeated.
    function automatic logic [31:0] ref_wdata(input int size, input logic [31:0] v);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = v[8*(i % size) +: 8];
        return w;
    endfunction

    // Assemble size bytes starting at off as an integer, then apply two's-complement sign.
    function automatic logic [31:0] ref_load(input int size, input bit uns, input int off,
                                             input logic [31:0] word);
        longint val;
        val = 0;
        for (int k = 0; k < size; k++) val += longint'(word[8*(off+k) +: 8]) << (8*k);
        if (!uns && size < 4 && val >= (longint'(1) << (8*size - 1)))
            val -= longint'(1) << (8*size);
        return val[31:0];
    endfunction

    function automatic funct3_mem_e ref_f3(input int size, input bit uns);
        case (size)
            1:       return uns ? F3_BU : F3_B;
            2:       return uns ? F3_HU : F3_H;
            default: return F3_W;
        endcase
    endfunction

    // kind: 0 = ALU op, 1 = load, 2 = store. gd = cycles before gnt, rdly = cycles after gnt+1 before rvalid.
    task automatic run_op(input string tag, input int kind, input int size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                          input logic [4:0] rd, input int gd, input int rdly);
        int  off, n;
        bit  mem, mis, tmo, flt, req_exp;
        off = int'(addr[1:0]);
        mem = (kind != 0);
        mis = mem && (off % size != 0);
        tmo = 1'b0;
        if (!mem || mis)          n = 1;
        else if (gd > TMO)        begin n = TMO + 1;      tmo = 1'b1; end
        else if (kind == 2)       n = gd + 1;
        else if (rdly >= TMO)     begin n = gd + 1 + TMO; tmo = 1'b1; end
        else                      n = gd + 2 + rdly;
        flt = mis || tmo;

        ex_mem_in.alu_result      = addr;
        ex_mem_in.rs2_data_str    = rs2;
        ex_mem_in.rd_addr         = rd;
        ex_mem_in.ctrl.reg_write  = (kind != 2);
        ex_mem_in.ctrl.mem_read   = (kind == 1);
        ex_mem_in.ctrl.mem_write  = (kind == 2);
        ex_mem_in.ctrl.mem_funct3 = ref_f3(size, uns);
        ex_mem_in.valid_ex_mem    = 1'b1;

        for (int c = 0; c < n; c++) begin
            dmem_gnt    = mem && !mis && (c == gd);
            dmem_rvalid = 1'b0;
            dmem_rdata  = 32'hDEAD_BEEF;
            if (kind == 1 && !mis && c == gd + 1 + rdly) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = rdata;
            end else if (mem && c > 0 && c < gd && $urandom_range(0, 1) == 1) begin
                dmem_rvalid = 1'b1;
            end
            #1;
            if (c == 0) begin
                chk({tag, ".fwd_alu"}, mem_alu_result, addr);
                chk({tag, ".fwd_rd"}, 32'(mem_rd_addr), 32'(rd));
                chk({tag, ".fwd_rw"}, 32'(mem_reg_write), 32'(kind != 2));
            end
            req_exp = mem && !mis && (c <= gd);
            chk({tag, ".req"}, 32'(dmem_req), 32'(req_exp));
            chk({tag, ".stall"}, 32'(mem_stall), 32'(c != n - 1));
            if (req_exp) begin
                chk({tag, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
                chk({tag, ".we"}, 32'(dmem_we), 32'(kind == 2));
                if (kind == 2) begin
                    chk({tag, ".be"}, 32'(dmem_be), 32'(ref_be(size, off)));
                    chk({tag, ".wdata"}, dmem_wdata, ref_wdata(size, rs2));
                end
            end
            @(posedge clk);
            #1;
            chk({tag, ".wb_vld"}, 32'(mem_wb_out.valid_mem_wb), 32'(c == n - 1));
            chk({tag, ".fault_pulse"}, 32'(mem_fault), 32'((c == n - 1) && flt));
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        chk({tag, ".wb_alu"}, mem_wb_out.alu_result, addr);
        chk({tag, ".wb_rd"}, 32'(mem_wb_out.rd_addr), 32'(rd));
        chk({tag, ".wb_rw"}, 32'(mem_wb_out.ctrl.reg_write), 32'((kind != 2) && !flt));
        chk({tag, ".wb_fault"}, 32'(mem_wb_out.fault), 32'(flt));
        if (kind == 1 && !flt)
            chk({tag, ".wb_rdata"}, mem_wb_out.mem_rdata, ref_load(size, uns, off, rdata));
    endtask

    initial begin
        int kind, size, rd_d, gd;
        bit uns;
        reset       = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        ex_mem_in   = '0;
        ex_mem_in.ctrl.mem_read   = 1'b1;
        ex_mem_in.ctrl.mem_funct3 = F3_W;
        ex_mem_in.valid_ex_mem    = 1'b1;
        #12;
        chk("rst.req", 32'(dmem_req), 32'd0);
        chk("rst.wb_vld", 32'(mem_wb_out.valid_mem_wb), 32'd0);
        chk("rst.wb_alu", mem_wb_out.alu_result, 32'd0);
        chk("rst.fault", 32'(mem_fault), 32'd0);
        ex_mem_in.valid_ex_mem = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_op("add",    0, 4, 1'b0, 32'h0000_0010, 32'h0, 32'h0,         5'd5, 0, 0);
        run_op("sb",     2, 1, 1'b0, 32'h0000_1003, 32'hAB, 32'h0,        5'd1, 0, 0);
        run_op("lh",     1, 2, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_1234, 5'd6, 3, 0);
        run_op("lbu",    1, 1, 1'b1, 32'h0000_2001, 32'h0, 32'h0000_F200, 5'd7, 0, 0);
        run_op("lw_mis", 1, 4, 1'b0, 32'h0000_3002, 32'h0, 32'h0,         5'd8, 0, 0);
        run_op("sh_mis", 2, 2, 1'b0, 32'h0000_3001, 32'h5A5A, 32'h0,      5'd0, 0, 0);
        run_op("ld_tmo", 1, 4, 1'b0, 32'h0000_4000, 32'h0, 32'h0,         5'd9, 0, 1000);
        run_op("st_tmo", 2, 4, 1'b0, 32'h0000_5000, 32'h1234, 32'h0,      5'd0, 1000, 0);
        run_op("sw",     2, 4, 1'b0, 32'h0000_5004, 32'hCAFE_F00D, 32'h0, 5'd0, 2, 0);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            case ($urandom_range(0, 2))
                0:       size = 1;
                1:       size = 2;
                default: size = 4;
            endcase
            if (kind == 0) size = 4;
            uns  = (kind == 1) && (size < 4) && ($urandom_range(0, 1) == 1);
            gd   = $urandom_range(0, 3);
            rd_d = $urandom_range(0, 3);
            run_op("rnd", kind, size, uns, $urandom, $urandom, $urandom,
                   5'($urandom_range(0, 31)), gd, rd_d);
        end

        // Invalid input is a bubble with no bus activity.
        ex_mem_in.valid_ex_mem = 1'b0;
        ex_mem_in.ctrl.mem_read = 1'b1;
        #1;
        chk("bubble.req", 32'(dmem_req), 32'd0);
        chk("bubble.stall", 32'(mem_stall), 32'd0);
        @(posedge clk);
        #1;
        chk("bubble.wb_vld", 32'(mem_wb_out.valid_mem_wb), 32'd0);

        // Reset while waiting for load data; a late rvalid must not write back.
        ex_mem_in.alu_result      = 32'h0000_6000;
        ex_mem_in.ctrl.mem_read   = 1'b1;
        ex_mem_in.ctrl.mem_write  = 1'b0;
        ex_mem_in.ctrl.mem_funct3 = F3_W;
        ex_mem_in.valid_ex_mem    = 1'b1;
        dmem_gnt = 1'b1;
        #1;
        chk("rstmid.req", 32'(dmem_req), 32'd1);
        @(posedge clk);
        #1;
        dmem_gnt = 1'b0;
        #1;
        chk("rstmid.stall", 32'(mem_stall), 32'd1);
        reset = 1'b0;
        #1;
        chk("rstmid.req_off", 32'(dmem_req), 32'd0);
        chk("rstmid.wb_vld", 32'(mem_wb_out.valid_mem_wb), 32'd0);
        ex_mem_in.valid_ex_mem = 1'b0;
        @(posedge clk);
        #1;
        reset       = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1234_5678;
        #1;
        chk("rstmid.stray_stall", 32'(mem_stall), 32'd0);
        @(posedge clk);
        #1;
        chk("rstmid.stray_wb", 32'(mem_wb_out.valid_mem_wb), 32'd0);
        chk("rstmid.stray_fault", 32'(mem_fault), 32'd0);
        dmem_rvalid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access pipeline stage directly downstream of the execute stage. It consumes the EX/MEM register (ex_mem_reg_t) and performs loads and stores over a req/gnt/rvalid data-memory bus, stalling the pipeline while a bus transaction is in flight. It produces the registered MEM/WB record (mem_wb_reg_t) and the MEM-side forwarding signals back to EX.

Parameters:
TIMEOUT_CYCLES, 64, cycles spent waiting in WAIT_GNT or WAIT_RDATA before the bus fault fires
ADDR_ALIGN_CHECK, 1, when 1, misaligned halfword/word accesses fault with no bus request

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
ex_mem_in  in  ex_mem_reg_t  EX/MEM record (alu_result, rs2_data_str, rd_addr, ctrl, valid_ex_mem)
dmem_req  out  1  bus request
dmem_we  out  1  1=store, 0=load
dmem_addr  out  XLEN  word-aligned address ({alu_result[XLEN-1:2],2'b00})
dmem_be  out  4  byte enables
dmem_wdata  out  XLEN  lane-shifted store data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  load data valid
dmem_rdata  in  XLEN  load data
mem_alu_result  out  XLEN  forward value to EX (ex_mem_in.alu_result)
mem_rd_addr  out  REG_ADDR_WIDTH  forward rd
mem_reg_write  out  1  ctrl.reg_write && valid_ex_mem
mem_stall  out  1  MEM not completing this cycle; freeze IF..EX and EX/MEM
mem_wb_out  out  mem_wb_reg_t  registered MEM/WB record
mem_fault  out  1  one-cycle pulse on misalign or timeout

Behaviour:
- Reset (reset=0, async): state=IDLE, timeout counter=0, mem_wb_out all zero (valid_mem_wb=0), mem_fault=0. dmem_req=0 combinationally while in reset.
- Memory ops are selected by ctrl.mem_read / ctrl.mem_write; width/sign come from ctrl.mem_funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- FSM IDLE -> WAIT_GNT -> WAIT_RDATA:
  - IDLE, valid non-memory op: no request; mem_wb_out loaded next edge; mem_stall=0. Latency 1.
  - IDLE, valid aligned memory op: dmem_req=1 combinationally. gnt same cycle: a store retires (mem_stall=0); a load goes to WAIT_RDATA (mem_stall=1). No gnt: go to WAIT_GNT with mem_stall=1.
  - WAIT_GNT: req, we, addr, be, wdata held stable until gnt; on gnt, retire the store or go to WAIT_RDATA for a load.
  - WAIT_RDATA: req=0; on rvalid, capture the extracted load into mem_wb_out, return to IDLE, mem_stall=0 that cycle. rvalid is never expected in the same cycle as its gnt; rvalid in IDLE or WAIT_GNT is ignored.
- Minimum load latency is 2 cycles (gnt cycle + rvalid cycle). Minimum store latency is 1 cycle.
- Store lanes: SB uses be=4'b0001<<addr[1:0] with the byte replicated; SH uses be=4'b0011<<addr[1:0] with the halfword replicated; SW uses be=4'b1111.
- Load extract: select the byte/halfword by addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- Misalign: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, when ADDR_ALIGN_CHECK=1:
  - no request is issued
  - mem_fault pulses
  - record retires with fault=1 and reg_write forced to 0
  - latency 1
- Timeout: the counter increments each cycle in WAIT_GNT/WAIT_RDATA and clears on leaving them. When it reaches TIMEOUT_CYCLES-1 with no progress:
  - retire with fault=1 and reg_write=0
  - mem_fault pulses
  - return to IDLE with req dropped
- While mem_stall=1, mem_wb_out.valid_mem_wb=0 each cycle (bubble toward WB). ex_mem_in must be held stable by upstream.
- Invalid input (valid_ex_mem=0): bubble, no request, mem_wb_out.valid_mem_wb=0.
- Forwarding outputs are combinational from ex_mem_in regardless of state. The hazard unit owns load-use stalls.
- Reset mid-transaction abandons the transaction and ignores a later stray rvalid.

Decomposition:
- riscv_pkg additions:
  - mem_wb_reg_t {alu_result, mem_rdata, rd_addr, ctrl, fault, valid_mem_wb}
  - mem_state_e {MEM_IDLE, MEM_WAIT_GNT, MEM_WAIT_RDATA}
  - ctrl.mem_funct3 field and funct3_mem_e load/store width enum
- Sub-module lsu_align: combinational store lane shift/be generation, load extract/extend, and the misalign flag.

Test Plan:
- ADD result 0x10, rd=5, no mem -> mem_wb_out.alu_result=0x10 and valid=1 one cycle later, no dmem_req.
- SB addr 0x1003, rs2=0xAB, gnt immediate -> be=4'b1000, wdata=0xABABABAB, addr=0x1000, mem_stall=0.
- LH addr 0x2002, gnt after 3 cycles, rdata=0x8001_1234 -> req held stable for 3 cycles, mem_stall high throughout, mem_rdata=0xFFFF8001.
- LBU addr 0x2001, rdata=0x0000_F200 -> mem_rdata=0x000000F2. Load latency exactly 2 cycles with immediate gnt.
- LW addr 0x3002 -> no req, mem_fault pulse, fault=1, reg_write=0.
- Load granted, rvalid withheld 64 cycles -> fault at cycle 64 and return to IDLE. Assert reset in WAIT_RDATA, then drive rvalid -> no writeback.
